// File: rtl/bin2bcd_seq_ctrl_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Used by the controller, its digit-adjust cells and the handshake interface.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] ADJ_THRESH  = 4'd5;
    localparam logic [3:0] ADJ_ADD     = 4'd3;
    localparam logic [3:0] BCD_MAX     = 4'd9;

endpackage

// File: rtl/bin2bcd_seq_ctrl_if.sv
// Request/result bundle of bin2bcd_seq_ctrl; i_abort exists only with BCD_ABORT_EN.
// master = requester (drives start/operand), slave = converter.
interface bin2bcd_seq_ctrl_if #(
    parameter int WIDTH  = 9,
    parameter int DIGITS = 3
);
    import bcd_pkg::*;

    logic                            i_start;
    logic [WIDTH-1:0]                i_bin_in;
`ifdef BCD_ABORT_EN
    logic                            i_abort;
`endif
    logic                            o_busy;
    logic                            o_done;
    logic [BCD_DIGIT_W*DIGITS-1:0]   o_bcd_out;

`ifdef BCD_ABORT_EN
    modport master (output i_start, i_bin_in, i_abort, input  o_busy, o_done, o_bcd_out);
    modport slave  (input  i_start, i_bin_in, i_abort, output o_busy, o_done, o_bcd_out);
`else
    modport master (output i_start, i_bin_in, input  o_busy, o_done, o_bcd_out);
    modport slave  (input  i_start, i_bin_in, output o_busy, o_done, o_bcd_out);
`endif

endinterface

// File: rtl/bin2bcd_seq_ctrl_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit in 5..9, passes others through.
// Latency: combinational. Backpressure: none.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_dig,
    output logic [BCD_DIGIT_W-1:0] o_dig
);

    // Values above 9 cannot occur in a legal accumulator, so they are left untouched.
    assign o_dig = (i_dig >= ADJ_THRESH && i_dig <= BCD_MAX) ? (i_dig + ADJ_ADD) : i_dig;

endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter, one add-3/shift pass per clock; optional BCD_ABORT_EN.
// Latency: done pulses WIDTH+1 cycles after the accepted start; one result per WIDTH+2 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
module bin2bcd_seq_ctrl
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int DIGITS = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    bin2bcd_seq_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;

    if (2**WIDTH - 1 > 10**DIGITS - 1) begin : g_range_chk
        $error("bin2bcd_seq_ctrl: DIGITS too small for WIDTH");
    end

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_bin_sr;
    logic [BCD_W-1:0]   r_acc;
    logic [BCD_W-1:0]   r_bcd_out;
    logic               r_busy;
    logic               r_done;

    logic [BCD_W-1:0]   w_acc_adj;
    logic               w_abort;
    logic               w_unused_msb;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_dig (r_acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_dig (w_acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // The top adjusted bit is shifted out; the range check guarantees it is always zero.
    assign w_unused_msb = w_acc_adj[BCD_W-1];

`ifdef BCD_ABORT_EN
    assign w_abort = bus.i_abort;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bin_sr  <= '0;
            r_acc     <= '0;
            r_bcd_out <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.i_start) begin
                        r_bin_sr <= bus.i_bin_in;
                        r_acc    <= '0;
                        r_cnt    <= CNT_W'(WIDTH);
                        r_busy   <= 1'b1;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_abort) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_acc    <= {w_acc_adj[BCD_W-2:0], r_bin_sr[WIDTH-1]};
                        r_bin_sr <= {r_bin_sr[WIDTH-2:0], 1'b0};
                        r_cnt    <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_bcd_out <= r_acc;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy    = r_busy;
    assign bus.o_done    = r_done;
    assign bus.o_bcd_out = r_bcd_out;

endmodule
